// File: rtl/rf_write_arbiter.sv
// Round-robin arbiter sharing the register-file write port among NREQ writeback sources,
// with bounded lock bursts and a registered output stage for the negedge write strobe.
module rf_write_arbiter #(
    parameter  int NREQ     = 3,
    parameter  int MAX_LOCK = 4,
    localparam int GW       = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ-1:0]   req_lock,
    input  logic [5*NREQ-1:0] req_addr,
    input  logic [32*NREQ-1:0] req_data,
    output logic [NREQ-1:0]   req_ready,
    output logic              rf_we,
    output logic [4:0]        rf_awr,
    output logic [31:0]       rf_din,
    output logic [GW-1:0]     rf_gnt_id,
    output logic              busy
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t        state;
    logic [GW-1:0] rr_ptr;
    logic [GW-1:0] owner;
    logic [3:0]    lock_cnt;

    logic [GW-1:0] gnt;
    logic          gnt_valid;
    logic [GW-1:0] next_ptr;
    logic [3:0]    lock_cnt_next;
    logic          burst_end;
    logic [4:0]    sel_addr;
    logic [31:0]   sel_data;

    // Scanning from the top down leaves the lowest rotated offset as the winner.
    always_comb begin : arbitrate
        int idx;
        idx       = 0;
        gnt       = '0;
        gnt_valid = 1'b0;
        if (!reset && !hold) begin
            if (state == LOCKED) begin
                gnt       = owner;
                gnt_valid = req_valid[owner];
            end else begin
                for (int k = NREQ - 1; k >= 0; k--) begin
                    idx = int'(rr_ptr) + k;
                    if (idx >= NREQ) idx = idx - NREQ;
                    if (req_valid[idx[GW-1:0]]) begin
                        gnt       = idx[GW-1:0];
                        gnt_valid = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt == GW'(i)) begin
                sel_addr = req_addr[5*i +: 5];
                sel_data = req_data[32*i +: 32];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (gnt_valid) req_ready[gnt] = 1'b1;
    end

    assign next_ptr      = (int'(gnt) == NREQ - 1) ? '0 : gnt + 1'b1;
    assign lock_cnt_next = lock_cnt + 4'd1;
    assign burst_end     = !req_lock[owner] || (lock_cnt_next == 4'(MAX_LOCK));
    assign busy          = (state == LOCKED);

    // gnt_valid is already suppressed under hold, so only the FSM needs an explicit freeze.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            owner     <= '0;
            lock_cnt  <= '0;
            rf_we     <= 1'b0;
            rf_awr    <= '0;
            rf_din    <= '0;
            rf_gnt_id <= '0;
        end else begin
            rf_we <= 1'b0;
            if (gnt_valid) begin
                rf_we     <= (sel_addr != 5'd0);
                rf_awr    <= sel_addr;
                rf_din    <= sel_data;
                rf_gnt_id <= gnt;
            end
            if (!hold) begin
                case (state)
                    IDLE: begin
                        if (gnt_valid) begin
                            rr_ptr   <= next_ptr;
                            lock_cnt <= 4'd1;
                            if (req_lock[gnt] && (MAX_LOCK > 1)) begin
                                state <= LOCKED;
                                owner <= gnt;
                            end
                        end
                    end
                    LOCKED: begin
                        if (gnt_valid) begin
                            lock_cnt <= lock_cnt_next;
                            if (burst_end) state <= IDLE;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Self-checking bench for rf_write_arbiter: directed vector table, an r0 sequence,
// and randomized traffic checked against a behavioural model.
module tb_rf_write_arbiter;

    localparam int N  = 3;
    localparam int ML = 4;
    localparam int GW = 2;
    localparam int NROWS = 29;
    localparam logic [5*N-1:0]  TA = {5'd3, 5'd2, 5'd1};
    localparam logic [32*N-1:0] TD = {32'h33333333, 32'h22222222, 32'h11111111};

    logic            clk;
    logic            reset;
    logic            hold;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_lock;
    logic [5*N-1:0]  req_addr;
    logic [32*N-1:0] req_data;
    logic [N-1:0]    req_ready;
    logic            rf_we;
    logic [4:0]      rf_awr;
    logic [31:0]     rf_din;
    logic [GW-1:0]   rf_gnt_id;
    logic            busy;

    int tests;
    int failed;

    // Behavioural model state
    bit          m_locked;
    int          m_owner;
    int          m_ptr;
    int          m_cnt;
    logic        m_we;
    logic [4:0]  m_awr;
    logic [31:0] m_din;
    logic [GW-1:0] m_gnt;

    typedef struct {
        logic [N-1:0]  valid;
        logic [N-1:0]  lock;
        logic          hold;
        logic          rst;
        logic [N-1:0]  ready;
        logic          we;
        logic [GW-1:0] gnt;
        logic          busy;
    } vec_t;

    vec_t tbl [NROWS];

    rf_write_arbiter #(.NREQ(N), .MAX_LOCK(ML)) dut (
        .clk       (clk),
        .reset     (reset),
        .hold      (hold),
        .req_valid (req_valid),
        .req_lock  (req_lock),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rf_we     (rf_we),
        .rf_awr    (rf_awr),
        .rf_din    (rf_din),
        .rf_gnt_id (rf_gnt_id),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Winner is the valid requester at the smallest rotated distance from the pointer.
    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r;
        int best;
        int bestd;
        int d;
        r = '0;
        best = -1;
        bestd = N;
        if (reset || hold) return r;
        if (m_locked) begin
            if (req_valid[m_owner]) r[m_owner] = 1'b1;
            return r;
        end
        for (int i = 0; i < N; i++) begin
            if (req_valid[i]) begin
                d = (i - m_ptr + N) % N;
                if (d < bestd) begin
                    bestd = d;
                    best = i;
                end
            end
        end
        if (best >= 0) r[best] = 1'b1;
        return r;
    endfunction

    task automatic model_step();
        logic [N-1:0] r;
        int g;
        r = model_ready();
        g = -1;
        for (int i = 0; i < N; i++) if (r[i]) g = i;
        if (reset) begin
            m_locked = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
            m_we = 1'b0; m_awr = '0; m_din = '0; m_gnt = '0;
        end else if (hold) begin
            m_we = 1'b0;
        end else if (g < 0) begin
            m_we = 1'b0;
            m_locked = 0;
        end else begin
            m_awr = req_addr[5*g +: 5];
            m_din = req_data[32*g +: 32];
            m_we  = (m_awr != 5'd0);
            m_gnt = GW'(g);
            if (m_locked) begin
                m_cnt++;
                if (!req_lock[g] || m_cnt == ML) m_locked = 0;
            end else begin
                m_ptr = (g + 1) % N;
                m_cnt = 1;
                if (req_lock[g] && ML > 1) begin
                    m_locked = 1;
                    m_owner = g;
                end
            end
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] v, input logic [N-1:0] l, input logic h,
                                 input logic r, input logic [5*N-1:0] a, input logic [32*N-1:0] d);
        req_valid = v;
        req_lock  = l;
        hold      = h;
        reset     = r;
        req_addr  = a;
        req_data  = d;
        #2;
    endtask

    task automatic advance();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic we, input logic [4:0] awr,
                               input logic [31:0] din, input logic [GW-1:0] gnt, input logic bsy);
        check({tag, " rf_we"},     32'(rf_we),     32'(we));
        check({tag, " rf_awr"},    32'(rf_awr),    32'(awr));
        check({tag, " rf_din"},    rf_din,         din);
        check({tag, " rf_gnt_id"}, 32'(rf_gnt_id), 32'(gnt));
        check({tag, " busy"},      32'(busy),      32'(bsy));
    endtask

    initial begin
        logic [5*N-1:0]  ra;
        logic [32*N-1:0] rd;
        logic [N-1:0]    exp_r;
        logic [31:0]     edin;

        tests = 0;
        failed = 0;
        m_locked = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
        m_we = 1'b0; m_awr = '0; m_din = '0; m_gnt = '0;
        reset = 1'b1; hold = 1'b0; req_valid = '0; req_lock = '0; req_addr = '0; req_data = '0;

        //             valid   lock    hold  rst   ready   we    gnt   busy
        tbl[0]  = '{3'b111, 3'b000, 1'b0, 1'b1, 3'b000, 1'b0, 2'd0, 1'b0};
        tbl[1]  = '{3'b111, 3'b000, 1'b0, 1'b0, 3'b001, 1'b1, 2'd0, 1'b0};
        tbl[2]  = '{3'b111, 3'b000, 1'b0, 1'b0, 3'b010, 1'b1, 2'd1, 1'b0};
        tbl[3]  = '{3'b111, 3'b000, 1'b0, 1'b0, 3'b100, 1'b1, 2'd2, 1'b0};
        tbl[4]  = '{3'b111, 3'b000, 1'b0, 1'b0, 3'b001, 1'b1, 2'd0, 1'b0};
        tbl[5]  = '{3'b111, 3'b000, 1'b0, 1'b0, 3'b010, 1'b1, 2'd1, 1'b0};
        tbl[6]  = '{3'b111, 3'b000, 1'b0, 1'b0, 3'b100, 1'b1, 2'd2, 1'b0};
        tbl[7]  = '{3'b011, 3'b000, 1'b0, 1'b0, 3'b001, 1'b1, 2'd0, 1'b0};
        tbl[8]  = '{3'b011, 3'b000, 1'b0, 1'b0, 3'b010, 1'b1, 2'd1, 1'b0};
        tbl[9]  = '{3'b111, 3'b100, 1'b0, 1'b0, 3'b100, 1'b1, 2'd2, 1'b1};
        tbl[10] = '{3'b111, 3'b100, 1'b0, 1'b0, 3'b100, 1'b1, 2'd2, 1'b1};
        tbl[11] = '{3'b111, 3'b100, 1'b0, 1'b0, 3'b100, 1'b1, 2'd2, 1'b1};
        tbl[12] = '{3'b111, 3'b100, 1'b0, 1'b0, 3'b100, 1'b1, 2'd2, 1'b0};
        tbl[13] = '{3'b111, 3'b000, 1'b0, 1'b0, 3'b001, 1'b1, 2'd0, 1'b0};
        tbl[14] = '{3'b001, 3'b001, 1'b0, 1'b0, 3'b001, 1'b1, 2'd0, 1'b1};
        tbl[15] = '{3'b011, 3'b001, 1'b0, 1'b0, 3'b001, 1'b1, 2'd0, 1'b1};
        tbl[16] = '{3'b010, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 2'd0, 1'b0};
        tbl[17] = '{3'b010, 3'b000, 1'b0, 1'b0, 3'b010, 1'b1, 2'd1, 1'b0};
        tbl[18] = '{3'b100, 3'b100, 1'b0, 1'b0, 3'b100, 1'b1, 2'd2, 1'b1};
        tbl[19] = '{3'b100, 3'b100, 1'b0, 1'b0, 3'b100, 1'b1, 2'd2, 1'b1};
        tbl[20] = '{3'b111, 3'b100, 1'b1, 1'b0, 3'b000, 1'b0, 2'd2, 1'b1};
        tbl[21] = '{3'b111, 3'b100, 1'b1, 1'b0, 3'b000, 1'b0, 2'd2, 1'b1};
        tbl[22] = '{3'b111, 3'b100, 1'b1, 1'b0, 3'b000, 1'b0, 2'd2, 1'b1};
        tbl[23] = '{3'b111, 3'b100, 1'b0, 1'b0, 3'b100, 1'b1, 2'd2, 1'b1};
        tbl[24] = '{3'b111, 3'b100, 1'b0, 1'b0, 3'b100, 1'b1, 2'd2, 1'b0};
        tbl[25] = '{3'b111, 3'b000, 1'b0, 1'b0, 3'b001, 1'b1, 2'd0, 1'b0};
        tbl[26] = '{3'b111, 3'b010, 1'b0, 1'b0, 3'b010, 1'b1, 2'd1, 1'b1};
        tbl[27] = '{3'b111, 3'b010, 1'b0, 1'b1, 3'b000, 1'b0, 2'd0, 1'b0};
        tbl[28] = '{3'b111, 3'b000, 1'b0, 1'b0, 3'b001, 1'b1, 2'd0, 1'b0};

        applyStimulus('0, '0, 1'b0, 1'b1, TA, TD);
        advance();

        for (int i = 0; i < NROWS; i++) begin
            applyStimulus(tbl[i].valid, tbl[i].lock, tbl[i].hold, tbl[i].rst, TA, TD);
            check($sformatf("row%0d req_ready", i), 32'(req_ready), 32'(tbl[i].ready));
            advance();
            check($sformatf("row%0d rf_we", i),     32'(rf_we),     32'(tbl[i].we));
            check($sformatf("row%0d rf_gnt_id", i), 32'(rf_gnt_id), 32'(tbl[i].gnt));
            check($sformatf("row%0d busy", i),      32'(busy),      32'(tbl[i].busy));
            if (tbl[i].rst) begin
                check($sformatf("row%0d rf_awr", i), 32'(rf_awr), 32'd0);
                check($sformatf("row%0d rf_din", i), rf_din, 32'd0);
            end else if (tbl[i].we) begin
                edin = 32'h11111111 * (32'(tbl[i].gnt) + 32'd1);
                check($sformatf("row%0d rf_awr", i), 32'(rf_awr), 32'(tbl[i].gnt) + 32'd1);
                check($sformatf("row%0d rf_din", i), rf_din, edin);
            end
        end

        // Write to r0 is consumed without rf_we and still advances the pointer.
        applyStimulus(3'b010, 3'b000, 1'b0, 1'b0, {5'd3, 5'd0, 5'd1},
                      {32'h33333333, 32'hDEADBEEF, 32'h11111111});
        check("r0 req_ready", 32'(req_ready), 32'b010);
        advance();
        checkOutput("r0", 1'b0, 5'd0, 32'hDEADBEEF, 2'd1, 1'b0);
        applyStimulus(3'b111, 3'b000, 1'b0, 1'b0, TA, TD);
        check("r0 next req_ready", 32'(req_ready), 32'b100);
        advance();
        checkOutput("r0 next", 1'b1, 5'd3, 32'h33333333, 2'd2, 1'b0);

        applyStimulus('0, '0, 1'b0, 1'b1, TA, TD);
        advance();
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < N; i++) begin
                ra[5*i +: 5]   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
                rd[32*i +: 32] = $urandom;
            end
            applyStimulus(3'($urandom), 3'($urandom), ($urandom_range(0, 9) == 0),
                          ($urandom_range(0, 59) == 0), ra, rd);
            exp_r = model_ready();
            check($sformatf("rand%0d req_ready", c), 32'(req_ready), 32'(exp_r));
            check($sformatf("rand%0d onehot", c), 32'($countones(req_ready) <= 1), 32'd1);
            advance();
            checkOutput($sformatf("rand%0d", c), m_we, m_awr, m_din, m_gnt, logic'(m_locked));
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
